// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the writer FSM state encoding.
package axi_pkg;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [2:0] SIZE_8B       = 3'b011;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic [1:0] RESP_OKAY     = 2'b00;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StAddr,
      StData,
      StResp,
      StDone
   } wr_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO; a push and a pop in the same cycle are legal when full.
module stream_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_push, do_pop;

   assign count   = wptr - rptr;
   assign empty   = (wptr == rptr);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/output_layer_writer.sv
// AXI4 burst-write master: buffers a 64-bit result stream and writes it to DDR in
// INCR bursts, one burst outstanding at a time.
module output_layer_writer
   import axi_pkg::*;
#(
   parameter int unsigned C_S_AXI_ID_WIDTH   = 3,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
   parameter int unsigned C_S_AXI_BURST_LEN  = 8,
   parameter int unsigned FIFO_DEPTH         = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_address,
   input  logic [15:0]                     total_beats,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   out_layer_data,
   input  logic                            out_layer_valid,
   output logic                            out_layer_rdy,
   output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
   output logic [7:0]                      M_axi_awlen,
   output logic [2:0]                      M_axi_awsize,
   output logic [1:0]                      M_axi_awburst,
   output logic                            M_axi_awlock,
   output logic [3:0]                      M_axi_awcache,
   output logic [2:0]                      M_axi_awprot,
   output logic [3:0]                      M_axi_awqos,
   output logic                            M_axi_awvalid,
   input  logic                            M_axi_awready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
   output logic                            M_axi_wlast,
   output logic                            M_axi_wvalid,
   input  logic                            M_axi_wready,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_bid,
   input  logic [1:0]                      M_axi_bresp,
   input  logic                            M_axi_bvalid,
   output logic                            M_axi_bready
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned LEN_W = 5;

   wr_state_e                     state_q, state_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [15:0]                   beats_left, total_q, acc_q;
   logic [LEN_W-1:0]              burst_beats, wcnt, cur_len;
   logic                          busy_q, done_q, error_q, rdy_q;

   logic                          push, pop, aw_hs, b_hs, start_ok;
   logic                          fifo_full, fifo_empty;
   logic [CNT_W-1:0]              fifo_count, cnt_d;
   logic [15:0]                   acc_d, total_d;
   logic                          busy_d, rdy_d;
   logic                          aw_valid, w_valid, b_ready;
   logic [C_S_AXI_ID_WIDTH-1:0]   unused_bid;

   assign unused_bid = M_axi_bid;

   stream_fifo #(
      .WIDTH (C_S_AXI_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (out_layer_data),
      .rdata (M_axi_wdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign start_ok = start & (state_q == StIdle);
   assign push     = out_layer_valid & rdy_q;
   assign pop      = w_valid & M_axi_wready;
   assign aw_hs    = aw_valid & M_axi_awready;
   assign b_hs     = b_ready & M_axi_bvalid;
   assign cur_len  = (beats_left < 16'(C_S_AXI_BURST_LEN)) ? beats_left[LEN_W-1:0]
                                                            : LEN_W'(C_S_AXI_BURST_LEN);

   always_comb begin
      state_d  = state_q;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      case (state_q)
         StIdle: if (start_ok) state_d = (total_beats == 16'd0) ? StDone : StWait;
         StWait: if (16'(fifo_count) >= 16'(cur_len)) state_d = StAddr;
         StAddr: begin
            aw_valid = 1'b1;
            if (M_axi_awready) state_d = StData;
         end
         StData: begin
            w_valid = ~fifo_empty;
            if (pop && M_axi_wlast) state_d = StResp;
         end
         StResp: begin
            b_ready = 1'b1;
            if (M_axi_bvalid) state_d = (beats_left != 16'd0) ? StWait : StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stream ready is registered, so it is computed from next-cycle occupancy and counts.
   always_comb begin
      cnt_d   = fifo_count + CNT_W'(push) - CNT_W'(pop);
      acc_d   = start_ok ? 16'd0 : acc_q + 16'(push);
      total_d = start_ok ? total_beats : total_q;
      busy_d  = start_ok ? 1'b1 : ((state_q == StDone) ? 1'b0 : busy_q);
      rdy_d   = busy_d && (cnt_d < CNT_W'(FIFO_DEPTH)) && (acc_d < total_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         beats_left  <= '0;
         total_q     <= '0;
         acc_q       <= '0;
         burst_beats <= '0;
         wcnt        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         total_q <= total_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
         done_q  <= (state_q == StDone);
         if (start_ok) begin
            addr_q     <= axi_address;
            beats_left <= total_beats;
            error_q    <= 1'b0;
         end
         if (state_q == StWait && state_d == StAddr) burst_beats <= cur_len;
         if (aw_hs) begin
            addr_q     <= addr_q + C_S_AXI_ADDR_WIDTH'({burst_beats, 3'b000});
            beats_left <= beats_left - 16'(burst_beats);
            wcnt       <= '0;
         end else if (pop) begin
            wcnt <= wcnt + 1'b1;
         end
         if (b_hs && M_axi_bresp != RESP_OKAY) error_q <= 1'b1;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign out_layer_rdy = rdy_q;

   assign M_axi_awid    = '0;
   assign M_axi_awaddr  = addr_q;
   assign M_axi_awlen   = 8'(burst_beats - 1'b1);
   assign M_axi_awsize  = SIZE_8B;
   assign M_axi_awburst = BURST_INCR;
   assign M_axi_awlock  = 1'b0;
   assign M_axi_awcache = CACHE_DEFAULT;
   assign M_axi_awprot  = 3'b000;
   assign M_axi_awqos   = 4'b0000;
   assign M_axi_awvalid = aw_valid;
   assign M_axi_wstrb   = '1;
   assign M_axi_wlast   = (wcnt == burst_beats - 1'b1);
   assign M_axi_wvalid  = w_valid;
   assign M_axi_bready  = b_ready;

endmodule

// File: tb/tb_output_layer_writer.sv
// Randomized bench for output_layer_writer with an AXI slave model and a burst-plan reference.
module tb_output_layer_writer;

   localparam int BL    = 8;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] axi_address;
   logic [15:0] total_beats;
   logic        busy, done, error;
   logic [63:0] out_layer_data;
   logic        out_layer_valid, out_layer_rdy;
   logic [2:0]  M_axi_awid;
   logic [31:0] M_axi_awaddr;
   logic [7:0]  M_axi_awlen;
   logic [2:0]  M_axi_awsize;
   logic [1:0]  M_axi_awburst;
   logic        M_axi_awlock;
   logic [3:0]  M_axi_awcache;
   logic [2:0]  M_axi_awprot;
   logic [3:0]  M_axi_awqos;
   logic        M_axi_awvalid, M_axi_awready;
   logic [63:0] M_axi_wdata;
   logic [7:0]  M_axi_wstrb;
   logic        M_axi_wlast, M_axi_wvalid, M_axi_wready;
   logic [2:0]  M_axi_bid;
   logic [1:0]  M_axi_bresp;
   logic        M_axi_bvalid, M_axi_bready;

   output_layer_writer dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .axi_address     (axi_address),
      .total_beats     (total_beats),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .out_layer_data  (out_layer_data),
      .out_layer_valid (out_layer_valid),
      .out_layer_rdy   (out_layer_rdy),
      .M_axi_awid      (M_axi_awid),
      .M_axi_awaddr    (M_axi_awaddr),
      .M_axi_awlen     (M_axi_awlen),
      .M_axi_awsize    (M_axi_awsize),
      .M_axi_awburst   (M_axi_awburst),
      .M_axi_awlock    (M_axi_awlock),
      .M_axi_awcache   (M_axi_awcache),
      .M_axi_awprot    (M_axi_awprot),
      .M_axi_awqos     (M_axi_awqos),
      .M_axi_awvalid   (M_axi_awvalid),
      .M_axi_awready   (M_axi_awready),
      .M_axi_wdata     (M_axi_wdata),
      .M_axi_wstrb     (M_axi_wstrb),
      .M_axi_wlast     (M_axi_wlast),
      .M_axi_wvalid    (M_axi_wvalid),
      .M_axi_wready    (M_axi_wready),
      .M_axi_bid       (M_axi_bid),
      .M_axi_bresp     (M_axi_bresp),
      .M_axi_bvalid    (M_axi_bvalid),
      .M_axi_bready    (M_axi_bready)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] stream [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      start           = 1'b0;
      out_layer_valid = 1'b0;
      out_layer_data  = 64'h0;
      M_axi_awready   = 1'b0;
      M_axi_wready    = 1'b0;
      M_axi_bvalid    = 1'b0;
      M_axi_bresp     = 2'b00;
      M_axi_bid       = 3'd0;
   endtask

   task automatic check_all_low(input string tag);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_error"}, 64'(error), 0);
      check({tag, "_rdy"}, 64'(out_layer_rdy), 0);
      check({tag, "_awvalid"}, 64'(M_axi_awvalid), 0);
      check({tag, "_wvalid"}, 64'(M_axi_wvalid), 0);
      check({tag, "_bready"}, 64'(M_axi_bready), 0);
   endtask

   // Called at posedge+1. Expected bursts are derived from total/base alone.
   task automatic run_xfer(input int total, input logic [31:0] base, input bit stall,
                           input int bad_burst, input int abort_at);
      int nbursts = (total + BL - 1) / BL;
      int sidx = 0, widx = 0, aw_n = 0, b_n = 0, b_owed = 0, done_n = 0;
      int cyc = 1, done_cyc = -1, k, len_k;
      bit exp_err = (bad_burst >= 0) && (bad_burst < nbursts);
      bit aw_stall = 0, w_stall = 0, b_hs = 0, aborted = 0;
      logic [31:0] aw_addr_s;
      logic [7:0]  aw_len_s;
      logic [63:0] w_data_s;
      logic        w_last_s, exp_last;

      stream.delete();
      for (int i = 0; i < total + 4; i++) stream.push_back({$urandom, $urandom});

      start       = 1'b1;
      axi_address = base;
      total_beats = 16'(total);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 64'(busy), 1);
      check("error_clear_on_start", 64'(error), 0);

      while (done_n == 0 && cyc < 4000) begin
         out_layer_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         out_layer_data  = (sidx < stream.size()) ? stream[sidx] : 64'h0;
         M_axi_awready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         M_axi_wready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!(M_axi_bvalid && !b_hs)) begin
            M_axi_bvalid = (b_owed > 0) && (!stall || $urandom_range(0, 2) == 0);
            M_axi_bresp  = (b_n == bad_burst) ? 2'b10 : 2'b00;
         end

         @(negedge clk);
         if (out_layer_rdy) check("rdy_beyond_total", 64'(sidx < total), 1);
         if (out_layer_valid && out_layer_rdy) begin
            check("fifo_overfill", 64'((sidx - widx) < DEPTH), 1);
            sidx++;
         end

         if (aw_stall && !M_axi_awvalid) check("awvalid_dropped", 0, 1);
         if (M_axi_awvalid) begin
            if (aw_stall) begin
               check("aw_stable_addr", 64'(M_axi_awaddr), 64'(aw_addr_s));
               check("aw_stable_len", 64'(M_axi_awlen), 64'(aw_len_s));
            end
            if (M_axi_awready) begin
               check("aw_count", 64'(aw_n < nbursts), 1);
               len_k = (total - aw_n * BL < BL) ? total - aw_n * BL : BL;
               check("awaddr", 64'(M_axi_awaddr), 64'(base + 32'(aw_n * BL * 8)));
               check("awlen", 64'(M_axi_awlen), 64'(len_k - 1));
               check("aw_consts", 64'({M_axi_awid, M_axi_awsize, M_axi_awburst, M_axi_awlock,
                                       M_axi_awcache, M_axi_awprot, M_axi_awqos}),
                     64'({3'd0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));
               aw_n++;
               aw_stall = 0;
            end else begin
               aw_stall  = 1;
               aw_addr_s = M_axi_awaddr;
               aw_len_s  = M_axi_awlen;
            end
         end

         if (w_stall && !M_axi_wvalid) check("wvalid_dropped", 0, 1);
         if (M_axi_wvalid) begin
            if (w_stall) begin
               check("w_stable_data", M_axi_wdata, w_data_s);
               check("w_stable_last", 64'(M_axi_wlast), 64'(w_last_s));
            end
            if (M_axi_wready) begin
               check("w_count", 64'(widx < total), 1);
               k        = widx / BL;
               len_k    = (total - k * BL < BL) ? total - k * BL : BL;
               exp_last = ((widx % BL) == len_k - 1);
               check("wdata", M_axi_wdata, (widx < stream.size()) ? stream[widx] : 64'h0);
               check("wlast", 64'(M_axi_wlast), 64'(exp_last));
               check("wstrb", 64'(M_axi_wstrb), 64'hFF);
               if (exp_last) b_owed++;
               widx++;
               w_stall = 0;
            end else begin
               w_stall  = 1;
               w_data_s = M_axi_wdata;
               w_last_s = M_axi_wlast;
            end
         end

         b_hs = M_axi_bvalid && M_axi_bready;
         if (b_hs) begin
            b_n++;
            b_owed--;
         end

         if (done) begin
            done_n++;
            done_cyc = cyc;
            check("busy_at_done", 64'(busy), 0);
            check("error_at_done", 64'(error), 64'(exp_err));
            check("beats_written", 64'(widx), 64'(total));
            check("beats_accepted", 64'(sidx), 64'(total));
            check("aw_total", 64'(aw_n), 64'(nbursts));
            check("b_total", 64'(b_n), 64'(nbursts));
         end

         if (abort_at >= 0 && widx >= abort_at && M_axi_wvalid) begin
            check("error_before_reset", 64'(error), 1);
            #2 reset = 1'b1;
            #1 check_all_low("mid_data_reset");
            idle_inputs();
            aborted = 1;
            break;
         end

         @(posedge clk); #1;
         cyc++;
      end

      if (aborted) begin
         @(posedge clk); @(posedge clk); #1;
         reset = 1'b0;
      end else begin
         if (done_n == 0) check("done_timeout", 0, 1);
         if (total == 0) check("zero_done_latency", 64'(done_cyc), 2);
         idle_inputs();
         out_layer_valid = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || M_axi_awvalid || M_axi_wvalid || out_layer_rdy)
               check("quiet_after_done", 0, 1);
            @(posedge clk); #1;
         end
         out_layer_valid = 1'b0;
      end
   endtask

   initial begin
      idle_inputs();
      axi_address = '0;
      total_beats = '0;
      reset       = 1'b1;
      repeat (2) @(negedge clk);
      check_all_low("reset_state");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_xfer(16, 32'h0000_1000, 1'b0, -1, -1);
      run_xfer(11, 32'h0000_2000, 1'b0, -1, -1);
      run_xfer(0,  32'h0000_3000, 1'b0, -1, -1);
      for (int r = 0; r < 4; r++)
         run_xfer(int'($urandom_range(1, 40)), $urandom & 32'hFFFF_FFC0, 1'b1, -1, -1);
      run_xfer(16, 32'h0000_4000, 1'b1, 0, -1);
      run_xfer(8,  32'h0000_5000, 1'b0, -1, -1);
      run_xfer(16, 32'h0000_6000, 1'b0, 0, 10);
      check_all_low("after_reset_release");
      run_xfer(8,  32'h0000_7000, 1'b0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
